// File: rtl/hex_display_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
package hex_display_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment vector {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low glyphs for hex digits 0..F (lower-case b and d).
  localparam seg7_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit common-anode display driver. A loaded word is held
// pending and only copied into the display register at the frame wrap, so a
// single scan never mixes digits from two different words.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  output logic [7:0]  an_o,
  output seg7_t       seg_o,
  output logic        dp_o,
  output logic        commit_o
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      pending;
  logic             pending_v;
  logic [31:0]      disp;

  logic             tick;
  logic             frame_wrap;
  logic [4:0]       shamt;
  logic [3:0]       nibble;
  logic             blank;
  seg7_t            seg_dec;

  assign tick       = (cnt == CNT_MAX);
  assign frame_wrap = tick && (idx == 3'(NUM_DIGITS - 1));

  // Bit offset of the current digit's nibble inside the display word.
  assign shamt  = {idx, 2'b00};
  assign nibble = disp[shamt +: 4];

  // A digit is a leading zero when it and everything above it is zero;
  // digit 0 always stays lit so a zero value still shows "0".
  assign blank  = blank_lz_i && (idx != 3'd0) && ((disp >> shamt) == 32'd0);

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  assign dp_o = 1'b1;

  // Prescaler and digit index: advance one digit every DIGIT_CYCLES clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      if (tick) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Capture loads into the pending register and commit at the frame wrap;
  // a load landing on the wrap itself bypasses straight into disp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= 32'd0;
      pending_v <= 1'b0;
      disp      <= 32'd0;
      commit_o  <= 1'b0;
    end else begin
      commit_o <= 1'b0;
      if (frame_wrap && (load_i || pending_v)) begin
        disp      <= load_i ? value_i : pending;
        pending_v <= 1'b0;
        commit_o  <= 1'b1;
      end else if (load_i) begin
        pending   <= value_i;
        pending_v <= 1'b1;
      end
    end
  end

  // Registered anode and segment drive for the digit selected this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_o  <= 8'hFF;
      seg_o <= SEG_BLANK;
    end else begin
      an_o  <= blank ? 8'hFF : ~(8'h01 << idx);
      seg_o <= blank ? SEG_BLANK : seg_dec;
    end
  end

endmodule
